// File: rtl/cpu_multiply_serial.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU. Latency is 34 edges from capture to result.
// Uses the latch/ready handshake: the result is held until the requester drops i_latch; dropping it early aborts.
module cpu_multiply_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_latch,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_ready,
   output logic [31:0] o_result
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state_q;
   logic [32:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] mcand_q;
   logic        neg_q;
   logic [1:0]  op_q;
   logic [4:0]  count_q;
   logic [31:0] result_q;

   logic        a_neg, b_neg;
   logic [32:0] sum;
   logic [63:0] prod;
   logic [63:0] prod_fix;

   always_comb begin
      a_neg    = i_a[31] & ((i_op == 2'b01) | (i_op == 2'b10));
      b_neg    = i_b[31] & (i_op == 2'b01);
      sum      = hi_q + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
      prod     = {hi_q[31:0], lo_q};
      prod_fix = neg_q ? (~prod + 64'd1) : prod;
   end

   // Operands are converted to magnitudes at capture; the sign is reapplied to the whole 64-bit product.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         neg_q    <= 1'b0;
         op_q     <= 2'b00;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_latch) begin
                  mcand_q <= a_neg ? (~i_a + 32'd1) : i_a;
                  lo_q    <= b_neg ? (~i_b + 32'd1) : i_b;
                  hi_q    <= '0;
                  neg_q   <= a_neg ^ b_neg;
                  op_q    <= i_op;
                  count_q <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (!i_latch) begin
                  state_q <= IDLE;
               end else begin
                  hi_q    <= {1'b0, sum[32:1]};
                  lo_q    <= {sum[0], lo_q[31:1]};
                  count_q <= count_q + 5'd1;
                  if (count_q == 5'd31) begin
                     state_q <= FIX;
                  end
               end
            end
            FIX: begin
               if (!i_latch) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= (op_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (!i_latch) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_ready  = (state_q == DONE) && i_latch;
   assign o_result = result_q;

endmodule

// File: tb/tb_cpu_multiply_serial.sv
// Bench for cpu_multiply_serial: directed vector table, randomized ops against an arithmetic model, handshake corner cases.
module tb_cpu_multiply_serial;

   logic        clk;
   logic        rst;
   logic        i_latch;
   logic [1:0]  i_op;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_ready;
   logic [31:0] o_result;

   int tests = 0;
   int fails = 0;

   cpu_multiply_serial dut (
      .clk      (clk),
      .rst      (rst),
      .i_latch  (i_latch),
      .i_op     (i_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_ready  (o_ready),
      .o_result (o_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   // Reference: extend each operand per its signedness, take the 64-bit product, pick the word.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ax, bx, p;
      ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
      bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ax * bx;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after an edge; the next edge is the capture edge E.
   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int n;
      i_op = op; i_a = a; i_b = b; i_latch = 1'b1;
      n = 0;
      while (!o_ready && n < 40) begin
         tick();
         n++;
      end
      chk({name, " latency"}, n, 34);
      chk({name, " result"}, o_result, exp);
      i_latch = 1'b0;
      #1;
      chk({name, " ready_drop"}, {31'd0, o_ready}, 32'd0);
      tick();
   endtask

   vec_t vecs[6];

   initial begin
      logic [31:0] prev;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      bit          seen;

      rst = 1'b1; i_latch = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
      tick(); tick();
      chk("reset_ready", {31'd0, o_ready}, 32'd0);
      chk("reset_result", o_result, 32'd0);
      rst = 1'b0;
      tick();

      // MUL 7x6 with explicit per-edge ready checks
      i_op = 2'b00; i_a = 32'd7; i_b = 32'd6; i_latch = 1'b1;
      seen = 1'b0;
      for (int k = 0; k <= 32; k++) begin
         tick();
         if (o_ready) seen = 1'b1;
      end
      chk("mul7x6 early_ready", {31'd0, seen}, 32'd0);
      tick();
      chk("mul7x6 ready", {31'd0, o_ready}, 32'd1);
      chk("mul7x6 result", o_result, 32'd42);
      i_latch = 1'b0;
      #1;
      chk("mul7x6 ready_drop", {31'd0, o_ready}, 32'd0);
      tick();

      vecs[0] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
      vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
      vecs[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      vecs[5] = '{2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
      for (int i = 0; i < 6; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Operands change right after capture
      i_op = 2'b11; i_a = 32'h10000; i_b = 32'h10000; i_latch = 1'b1;
      tick();
      i_a = 32'hDEADBEEF; i_b = 32'h12345678; i_op = 2'b00;
      for (int k = 0; k < 33; k++) tick();
      chk("opchg ready", {31'd0, o_ready}, 32'd1);
      chk("opchg result", o_result, 32'h00000001);
      i_latch = 1'b0;
      tick();

      // Abort: latch sampled low at E+10
      prev = o_result;
      i_op = 2'b00; i_a = 32'd100; i_b = 32'd100; i_latch = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      i_latch = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (o_ready) seen = 1'b1;
      end
      chk("abort ready", {31'd0, seen}, 32'd0);
      chk("abort result_hold", o_result, prev);
      do_op("after_abort 3x5", 2'b00, 32'd3, 32'd5, 32'd15);

      // Reset sampled at E+20 of a MUL
      i_op = 2'b00; i_a = 32'd9; i_b = 32'd9; i_latch = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      rst = 1'b1;
      tick();
      chk("midrun_rst ready", {31'd0, o_ready}, 32'd0);
      chk("midrun_rst result", o_result, 32'd0);
      i_latch = 1'b0;
      tick();
      // Latch rises together with reset release: capture on first edge with rst low
      rst = 1'b0;
      do_op("rst_release", 2'b00, 32'd11, 32'd13, 32'd143);

      // Back-to-back with one-edge gap; previous result held until op2 FIX
      do_op("b2b op1", 2'b00, 32'd2, 32'd3, 32'd6);
      i_op = 2'b01; i_a = 32'h7FFFFFFF; i_b = 32'h7FFFFFFF; i_latch = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 33; k++) begin
         tick();
         if (o_result !== 32'd6) seen = 1'b1;
      end
      chk("b2b hold", {31'd0, seen}, 32'd0);
      tick();
      chk("b2b op2 ready", {31'd0, o_ready}, 32'd1);
      chk("b2b op2 result", o_result, 32'h3FFFFFFF);
      i_latch = 1'b0;
      tick();

      // Randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: rb = 32'hFFFFFFFF;
            2: ra = 32'd0;
            default: ;
         endcase
         do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_multiply_serial.md
# cpu_multiply_serial

Iterative radix-2 shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It sits beside the pipelined divider in the CPU execute stage and uses the same latch/ready handshake, so the execute controller drives both units identically. It trades DSP usage for a fixed 34-cycle latency and captures its operands internally, so they need not stay stable after the first sampling edge.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_latch  in  1  request. Held high by the requester until o_ready is seen.
- i_op  in  2  operation select:
  - 00 MUL (low 32 bits)
  - 01 MULH (signed×signed, high 32 bits)
  - 10 MULHSU (signed a × unsigned b, high 32 bits)
  - 11 MULHU (unsigned×unsigned, high 32 bits)
- i_a  in  32  multiplicand (rs1).
- i_b  in  32  multiplier (rs2).
- o_ready  out  1  result valid. Combinational: (state==DONE) && i_latch.
- o_result  out  32  registered result.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, i_latch=1:
  - Capture a_neg = i_a[31] & (i_op==01 | i_op==10); b_neg = i_b[31] & (i_op==01).
  - Capture mcand = a_neg ? -i_a : i_a and lo = b_neg ? -i_b : i_b.
  - Capture hi=0 (33 bits), neg = a_neg^b_neg, op=i_op, count=0. Go to RUN.
- RUN, each edge:
  - sum = hi + (lo[0] ? {1'b0,mcand} : 0), 33 bits.
  - {hi,lo} <= {sum,lo} >> 1. count++.
  - At count==31 go to FIX.
- FIX:
  - p = {hi[31:0],lo}, 64 bits. If neg, p = -p (two's complement, 64-bit).
  - o_result <= (op==00) ? p[31:0] : p[63:32]. Go to DONE.
- DONE: stay while i_latch=1. i_latch=0 -> IDLE.
- i_latch=0 in RUN or FIX: abort to IDLE on that edge. o_result is not updated.
- i_op/i_a/i_b are ignored after the capture edge.
- MUL result equals the low word regardless of sign handling; the negation path covers it correctly.
- All operand values are legal; there is no overflow or error case.
  - 0x80000000 magnitude is 0x80000000 unsigned, computed correctly by 32-bit two's complement.
  - MULH(0x80000000,0x80000000) = 0x40000000.

## Timing
- Reset values: state=IDLE, o_result=0, o_ready=0. Internal regs: count=0, hi=0, lo=0, neg=0.
- rst overrides all transitions, including mid-RUN.
- Latency: i_latch first sampled high at edge E.
  - E: capture.
  - E+1..E+32: iterations.
  - E+33: FIX writes o_result and enters DONE.
  - o_ready is high in the cycle after E+33 (34 edges, inclusive of E).
- o_ready drops in the same cycle i_latch drops; there is no registered tail.
- Back-to-back operations: i_latch must be low for at least one sampled edge between requests (DONE->IDLE). The earliest new capture is the following edge.
- o_result holds its value until the next FIX. It is stable during DONE and after DONE->IDLE.
- i_latch rising in the same cycle rst deasserts: capture happens on the first edge with rst=0.

## Test plan
- MUL a=7, b=6, latch held:
  - o_ready low for edges E..E+32.
  - o_ready high after E+33 with o_result=42.
  - Drop latch: o_ready low in that same cycle.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000.
- MULH a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF (product 0xFFFFFFFF_00000001).
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE.
- MUL with the same operands -> 0x00000001.
- Operand change after capture: MULHU 0x10000 × 0x10000, then change i_a/i_b at E+1.
  - Result is still 0x00000001.
- Abort and reset:
  - Drop i_latch at E+10: o_ready never rises and o_result keeps its previous value.
  - Re-raise latch with MUL 3×5: result 15 after a fresh 34 edges.
  - Assert rst at E+20 of a MUL: state IDLE, o_result=0, o_ready=0.
- Back-to-back:
  - Op1 MUL 2×3 -> 6. Drop latch 1 cycle.
  - Op2 MULH 0x7FFFFFFF×0x7FFFFFFF -> 0x3FFFFFFF.
  - o_result=6 is held through the gap until op2's FIX edge.
